// File: rtl/core_seq_pkg.sv
// Shared encodings for the framed command sequencer: state codes, error codes,
// default sync marker and a small state-class helper.
package core_seq_pkg;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_GET_INS  = 4'd1;
  localparam logic [3:0] ST_GET_AH   = 4'd2;
  localparam logic [3:0] ST_GET_AL   = 4'd3;
  localparam logic [3:0] ST_GET_BH   = 4'd4;
  localparam logic [3:0] ST_GET_BL   = 4'd5;
  localparam logic [3:0] ST_EXEC     = 4'd6;
  localparam logic [3:0] ST_WAIT_C   = 4'd7;
  localparam logic [3:0] ST_TX_MSB   = 4'd8;
  localparam logic [3:0] ST_WAIT_MSB = 4'd9;
  localparam logic [3:0] ST_TX_LSB   = 4'd10;
  localparam logic [3:0] ST_WAIT_LSB = 4'd11;

  // GET_* codes are consecutive and GET_BL + 1 == EXEC; the byte-load path relies on this.
  typedef enum logic [3:0] {
    S_IDLE     = ST_IDLE,
    S_GET_INS  = ST_GET_INS,
    S_GET_AH   = ST_GET_AH,
    S_GET_AL   = ST_GET_AL,
    S_GET_BH   = ST_GET_BH,
    S_GET_BL   = ST_GET_BL,
    S_EXEC     = ST_EXEC,
    S_WAIT_C   = ST_WAIT_C,
    S_TX_MSB   = ST_TX_MSB,
    S_WAIT_MSB = ST_WAIT_MSB,
    S_TX_LSB   = ST_TX_LSB,
    S_WAIT_LSB = ST_WAIT_LSB
  } state_e;

  localparam logic [1:0] ERR_NONE        = 2'd0;
  localparam logic [1:0] ERR_RX_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_ALU_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_RX_OVERRUN  = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  function automatic logic is_get_state(input state_e s);
    return (s >= S_GET_INS) && (s <= S_GET_BL);
  endfunction

endpackage

// File: rtl/seq_timeout_cnt.sv
// Idle-cycle counter shared by the RX inter-byte and ALU watchdog timeouts.
// Counts up while enabled, saturates at the limit, expire is a plain compare.
module seq_timeout_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_in,
  input  logic             en_in,
  input  logic [CNT_W-1:0] limit_in,
  output logic             expire_out
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expire_out = (cnt_q == limit_in);

  // next count: clear wins, otherwise count until the limit and hold there
  always_comb begin
    cnt_d = cnt_q;
    if (clr_in) begin
      cnt_d = '0;
    end else if (en_in && !expire_out) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Framed command sequencer: sync hunt, opcode/operand load, ALU fire with
// watchdog, two-byte result return over TX, plus RX timeout/overrun errors.
//
// state    | meaning
// IDLE     | hunting for the sync byte
// GET_INS  | next RX byte is the opcode
// GET_AH   | next RX byte is a[15:8]
// GET_AL   | next RX byte is a[7:0]
// GET_BH   | next RX byte is b[15:8]
// GET_BL   | next RX byte is b[7:0]
// EXEC     | one-cycle ALU start pulse
// WAIT_C   | waiting for the ALU result, watchdog running
// TX_MSB   | one-cycle TX start for c[15:8]
// WAIT_MSB | waiting for the UART to finish c[15:8]
// TX_LSB   | one-cycle TX start for c[7:0]
// WAIT_LSB | waiting for the UART to finish c[7:0]
module frame_sequencer
  import core_seq_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYC  = 50000,
  parameter int         ALU_WAIT_MAX = 16,
  parameter int         CNT_W        = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Rx_DV_in,
  input  logic [7:0] Rx_Byte_in,
  input  logic       Tx_Done_in,
  input  logic       c_valid_in,
  output logic       En_out,
  output logic       Load_INS_en_out,
  output logic       Load_MSB_a_en_out,
  output logic       Load_LSB_a_en_out,
  output logic       Load_MSB_b_en_out,
  output logic       Load_LSB_b_en_out,
  output logic       Tx_DV_out,
  output logic       MLSB_SEL_Tx_Byte_out,
  output logic       Busy_out,
  output logic       Err_out,
  output logic [1:0] Err_code_out
);

  localparam logic [CNT_W-1:0] RX_LIMIT  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] ALU_LIMIT = CNT_W'(ALU_WAIT_MAX - 1);

  state_e     state_q;
  state_e     state_d;
  logic [1:0] err_code_q;
  logic [1:0] err_code_d;
  logic       mlsb_q;
  logic       mlsb_d;
  logic       err_pulse;
  logic       cnt_clr;
  logic       cnt_en;
  logic       cnt_expire;
  logic [CNT_W-1:0] cnt_limit;

  // one counter serves both timeouts; only WAIT_C uses the ALU limit
  assign cnt_limit = (state_q == S_WAIT_C) ? ALU_LIMIT : RX_LIMIT;

  seq_timeout_cnt #(
    .CNT_W(CNT_W)
  ) u_timeout_cnt (
    .clk       (CLK),
    .rst       (RST),
    .clr_in    (cnt_clr),
    .en_in     (cnt_en),
    .limit_in  (cnt_limit),
    .expire_out(cnt_expire)
  );

  // next state, error capture and timeout counter control
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    err_pulse  = 1'b0;
    cnt_clr    = 1'b1;
    cnt_en     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Rx_DV_in && (Rx_Byte_in == SYNC_BYTE)) begin
          state_d = S_GET_INS;
        end
      end
      S_GET_INS, S_GET_AH, S_GET_AL, S_GET_BH, S_GET_BL: begin
        cnt_en  = 1'b1;
        cnt_clr = Rx_DV_in;
        // a byte arriving on the expiry cycle still wins
        if (Rx_DV_in) begin
          state_d = state_e'(state_q + 4'd1);
        end else if (cnt_expire) begin
          state_d    = S_IDLE;
          err_pulse  = 1'b1;
          err_code_d = ERR_RX_TIMEOUT;
        end
      end
      S_EXEC: begin
        state_d = c_valid_in ? S_TX_MSB : S_WAIT_C;
      end
      S_WAIT_C: begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b1;
        if (c_valid_in) begin
          state_d = S_TX_MSB;
        end else if (cnt_expire) begin
          state_d    = S_IDLE;
          err_pulse  = 1'b1;
          err_code_d = ERR_ALU_TIMEOUT;
        end
      end
      S_TX_MSB: state_d = S_WAIT_MSB;
      S_WAIT_MSB: begin
        if (Tx_Done_in) begin
          state_d = S_TX_LSB;
        end
      end
      S_TX_LSB: state_d = S_WAIT_LSB;
      S_WAIT_LSB: begin
        if (Tx_Done_in) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // stray RX byte after the operands are in: flag it, keep the sequence going
    if (Rx_DV_in && (state_q >= S_EXEC) && !err_pulse) begin
      err_pulse  = 1'b1;
      err_code_d = ERR_RX_OVERRUN;
    end

    // mux select follows the byte being sent and stays put through its WAIT state
    mlsb_d = (state_d == S_TX_LSB) || (state_d == S_WAIT_LSB);
  end

  // state, sticky error code and TX mux select registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      err_code_q <= ERR_NONE;
      mlsb_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
      mlsb_q     <= mlsb_d;
    end
  end

  assign Load_INS_en_out      = (state_q == S_GET_INS) && Rx_DV_in;
  assign Load_MSB_a_en_out    = (state_q == S_GET_AH)  && Rx_DV_in;
  assign Load_LSB_a_en_out    = (state_q == S_GET_AL)  && Rx_DV_in;
  assign Load_MSB_b_en_out    = (state_q == S_GET_BH)  && Rx_DV_in;
  assign Load_LSB_b_en_out    = (state_q == S_GET_BL)  && Rx_DV_in;
  assign En_out               = (state_q == S_EXEC);
  assign Tx_DV_out            = (state_q == S_TX_MSB) || (state_q == S_TX_LSB);
  assign MLSB_SEL_Tx_Byte_out = mlsb_q;
  assign Busy_out             = (state_q != S_IDLE);
  assign Err_out              = err_pulse;
  assign Err_code_out         = err_code_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: table of full frames plus hand
// sequences for sync hunt, timeouts, overrun and mid-frame reset. Returned
// TX bytes are checked against a scoreboard filled when the ALU model answers.
module tb_frame_sequencer;

  localparam int TB_TIMEOUT = 40;
  localparam int TB_ALU_MAX = 16;

  logic       clk;
  logic       rst;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       tx_done;
  logic       c_valid;
  logic       en;
  logic       ld_ins, ld_ah, ld_al, ld_bh, ld_bl;
  logic       tx_dv;
  logic       mlsb;
  logic       busy;
  logic       err;
  logic [1:0] err_code;

  frame_sequencer #(
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (TB_TIMEOUT),
    .ALU_WAIT_MAX(TB_ALU_MAX),
    .CNT_W       (16)
  ) dut (
    .CLK                 (clk),
    .RST                 (rst),
    .Rx_DV_in            (rx_dv),
    .Rx_Byte_in          (rx_byte),
    .Tx_Done_in          (tx_done),
    .c_valid_in          (c_valid),
    .En_out              (en),
    .Load_INS_en_out     (ld_ins),
    .Load_MSB_a_en_out   (ld_ah),
    .Load_LSB_a_en_out   (ld_al),
    .Load_MSB_b_en_out   (ld_bh),
    .Load_LSB_b_en_out   (ld_bl),
    .Tx_DV_out           (tx_dv),
    .MLSB_SEL_Tx_Byte_out(mlsb),
    .Busy_out            (busy),
    .Err_out             (err),
    .Err_code_out        (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // bench-side memories, ALU result register and event counters
  logic [7:0]  ins_m, ah_m, al_m, bh_m, bl_m;
  logic [15:0] alu_c;
  logic [4:0]  ld_vec;
  logic [7:0]  sb_exp;
  logic [7:0]  sb_act;
  logic [7:0]  sb[$];
  int load_cnt, en_cnt, tx_cnt, err_cnt;

  typedef struct {
    logic [7:0]  ins, ah, al, bh, bl;
    logic [15:0] c;
    int          lat;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    tick();
    rx_dv   = 1'b0;
  endtask

  task automatic clear_counts();
    load_cnt = 0;
    en_cnt   = 0;
    tx_cnt   = 0;
    err_cnt  = 0;
  endtask

  task automatic wait_tx(input string name);
    for (int i = 0; i < 40 && !tx_dv; i++) tick();
    chk(name, tx_dv, 1);
  endtask

  // called in the EXEC cycle; models the ALU and the UART TX side
  task automatic exec_and_tx(input logic [15:0] c, input int lat, input bit inject);
    chk("en_pulse", en, 1);
    repeat (lat) tick();
    c_valid = 1'b1;
    alu_c   = c;
    sb.push_back(c[15:8]);
    sb.push_back(c[7:0]);
    tick();
    c_valid = 1'b0;
    chk("tx_msb_latency", tx_dv, 1);
    chk("mlsb_msb", mlsb, 0);
    tick();
    chk("mlsb_hold_msb", mlsb, 0);
    if (inject) begin
      rx_dv   = 1'b1;
      rx_byte = 8'h77;
      #1;
      chk("overrun_err_pulse", err, 1);
      tick();
      rx_dv = 1'b0;
      chk("overrun_code", err_code, 3);
      chk("overrun_busy", busy, 1);
    end
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    wait_tx("tx_lsb_seen");
    chk("mlsb_lsb", mlsb, 1);
    tick();
    chk("mlsb_hold_lsb", mlsb, 1);
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("idle_after_tx", busy, 0);
    chk("mlsb_idle", mlsb, 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic run_frame(input vec_t v, input bit inject);
    clear_counts();
    send_byte(8'hA5);
    send_byte(v.ins);
    send_byte(v.ah);
    send_byte(v.al);
    send_byte(v.bh);
    send_byte(v.bl);
    exec_and_tx(v.c, v.lat, inject);
    chk("mem_ins", ins_m, v.ins);
    chk("mem_ah", ah_m, v.ah);
    chk("mem_al", al_m, v.al);
    chk("mem_bh", bh_m, v.bh);
    chk("mem_bl", bl_m, v.bl);
    chk("load_count", load_cnt, 5);
    chk("en_count", en_cnt, 1);
    chk("tx_count", tx_cnt, 2);
    chk("err_count", err_cnt, inject ? 1 : 0);
  endtask

  // monitor: memory capture, one-hot load check, event counts, TX scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      ld_vec = {ld_ins, ld_ah, ld_al, ld_bh, ld_bl};
      if (ld_vec != 5'b0) begin
        load_cnt++;
        chk("load_onehot", $countones(ld_vec), 1);
        if (ld_ins) ins_m = rx_byte;
        if (ld_ah)  ah_m  = rx_byte;
        if (ld_al)  al_m  = rx_byte;
        if (ld_bh)  bh_m  = rx_byte;
        if (ld_bl)  bl_m  = rx_byte;
      end
      if (en)  en_cnt++;
      if (err) err_cnt++;
      if (tx_dv) begin
        tx_cnt++;
        if (sb.size() == 0) begin
          chk("tx_unexpected", tx_cnt, 0);
        end else begin
          sb_exp = sb.pop_front();
          sb_act = mlsb ? alu_c[7:0] : alu_c[15:8];
          chk("tx_byte", sb_act, sb_exp);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    tx_done = 1'b0;
    c_valid = 1'b0;
    alu_c   = 16'h0000;
    ins_m = 8'h00; ah_m = 8'h00; al_m = 8'h00; bh_m = 8'h00; bl_m = 8'h00;
    clear_counts();

    vecs[0] = '{8'h01, 8'h00, 8'h08, 8'h00, 8'h10, 16'h0018, 3};
    vecs[1] = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 16'hBEEF, 0};
    vecs[2] = '{8'h03, 8'hFF, 8'hFF, 8'h00, 8'h01, 16'hFFFE, TB_ALU_MAX};
    vecs[3] = '{8'hA5, 8'hA5, 8'h00, 8'hA5, 8'h5A, 16'h8001, 1};

    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_en", en, 0);
    chk("rst_tx_dv", tx_dv, 0);
    chk("rst_mlsb", mlsb, 0);

    // table of full frames
    for (int i = 0; i < 4; i++) run_frame(vecs[i], 1'b0);
    chk("code_after_frames", err_code, 0);

    // non-sync byte in IDLE is dropped silently
    clear_counts();
    send_byte(8'h3C);
    chk("junk_busy", busy, 0);
    chk("junk_err", err_cnt, 0);
    run_frame(vecs[0], 1'b0);

    // RX byte during WAIT_MSB: overrun error, TX still completes
    run_frame(vecs[1], 1'b1);

    // RX inter-byte timeout in GET_AL
    clear_counts();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    repeat (TB_TIMEOUT - 2) tick();
    chk("rxto_not_early", err, 0);
    tick();
    chk("rxto_err_pulse", err, 1);
    tick();
    chk("rxto_code", err_code, 1);
    chk("rxto_busy", busy, 0);
    chk("rxto_err_one", err_cnt, 1);
    chk("rxto_kept_ins", ins_m, 8'h01);

    // byte arrives on the expiry cycle: byte wins
    clear_counts();
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TB_TIMEOUT - 1) tick();
    rx_dv   = 1'b1;
    rx_byte = 8'h00;
    #1;
    chk("tie_no_err", err, 0);
    chk("tie_load_ah", ld_ah, 1);
    tick();
    rx_dv = 1'b0;
    chk("tie_busy", busy, 1);
    chk("tie_code_kept", err_code, 1);
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h10);
    exec_and_tx(16'h0018, 3, 1'b0);
    chk("tie_err_count", err_cnt, 0);
    chk("tie_mem_ah", ah_m, 8'h00);

    // ALU never answers
    clear_counts();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h10);
    chk("aluto_en", en, 1);
    repeat (TB_ALU_MAX - 1) tick();
    chk("aluto_not_early", err, 0);
    tick();
    chk("aluto_err_pulse", err, 1);
    tick();
    chk("aluto_code", err_code, 2);
    chk("aluto_busy", busy, 0);
    repeat (5) tick();
    chk("aluto_no_tx", tx_cnt, 0);

    // reset in the middle of a frame, then a clean frame
    clear_counts();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_code", err_code, 0);
    chk("mid_rst_tx", tx_dv, 0);
    tick();
    rst = 1'b0;
    tick();
    run_frame(vecs[3], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
